// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single-port SoC memory between the core's MAR/MDR path (port C)
// and the UART/debug loader (port D). One transaction is in flight at a time:
// arbitrate in IDLE, hold the request on the memory bus in BUS until ack or
// timeout, then pulse the owner's done for one cycle in RESP.
//
// Parameters
//   AW       address width
//   DW       data width (byte enables are DW/8 wide)
//   TIMEOUT  max cycles m_req may stay high without m_ack; 0 = wait forever
//
// Ports
//   clk, rst                      rising-edge clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata/c_be   core request (held until c_done)
//   c_done/c_rdata/c_err          core response; rdata/err valid with done
//   d_*                           loader request/response, same as port C
//   m_req/m_we/m_addr/m_wdata/m_be   memory bus request, held while m_req=1
//   m_rdata/m_ack                 memory read data, sampled on one-cycle ack
//   busy                          high while a transaction is in BUS or RESP
//   grant_id                      owner of current/last transaction (0=C,1=D)
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            c_req,
    input  logic            c_we,
    input  logic [AW-1:0]   c_addr,
    input  logic [DW-1:0]   c_wdata,
    input  logic [DW/8-1:0] c_be,
    output logic            c_done,
    output logic [DW-1:0]   c_rdata,
    output logic            c_err,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_done,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,

    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack,

    output logic            busy,
    output logic            grant_id
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
    // declaration stays legal when the timeout is disabled.
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TO_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t        state;
    logic          last_grant;   // 1 = D served last, so C wins the next tie
    logic [CW-1:0] to_cnt;

    logic          any_req;
    logic          pick_d;
    logic          to_hit;
    logic          finish;
    logic [DW-1:0] rsp_data;

    // Arbitration and completion decode
    always_comb begin
        any_req = c_req | d_req;

        // Round-robin only matters on a tie; a lone requester always wins.
        if (c_req && d_req) begin
            pick_d = ~last_grant;
        end else begin
            pick_d = d_req;
        end

        // Ack on the last allowed cycle still wins over the timeout.
        to_hit = TO_EN && !m_ack && (to_cnt == CNT_LAST);
        finish = m_ack || to_hit;

        // Writes and timeouts return zero data.
        rsp_data = (m_ack && !m_we) ? m_rdata : '0;
    end

    // Transaction sequencer with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            to_cnt     <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_be       <= '0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            c_done     <= 1'b0;
            c_rdata    <= '0;
            c_err      <= 1'b0;
            d_done     <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            // done is a single-cycle pulse
            c_done <= 1'b0;
            d_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant_id   <= pick_d;
                        last_grant <= pick_d;
                        if (pick_d) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_be    <= d_be;
                        end else begin
                            m_we    <= c_we;
                            m_addr  <= c_addr;
                            m_wdata <= c_wdata;
                            m_be    <= c_be;
                        end
                        to_cnt <= '0;
                        m_req  <= 1'b1;
                        busy   <= 1'b1;
                        state  <= S_BUS;
                    end
                end

                S_BUS: begin
                    if (finish) begin
                        m_req <= 1'b0;
                        state <= S_RESP;
                        if (grant_id) begin
                            d_done  <= 1'b1;
                            d_rdata <= rsp_data;
                            d_err   <= ~m_ack;
                        end else begin
                            c_done  <= 1'b1;
                            c_rdata <= rsp_data;
                            c_err   <= ~m_ack;
                        end
                    end else if (TO_EN) begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end

                // Requests are not sampled here; a held req is re-arbitrated
                // in the following IDLE cycle.
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single-port SoC memory between two requesters: the core's MAR/MDR path (port C) and the UART/debug loader (port D). It sequences one transaction at a time: arbitrate, drive the memory bus, wait for acknowledge (with timeout), then return read data with a one-cycle done pulse. It sits between the core's memory microsequence and the memory/peripheral decode in soc_top.

Parameters:
AW, 32, address width
DW, 32, data width; byte-enable width is DW/8
TIMEOUT, 255, maximum cycles m_req may stay high without m_ack before abort; 0 disables the timeout
CW, $clog2(TIMEOUT+1) (minimum 1), timeout counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
c_req  in  1  core request; held with fields stable until c_done
c_we  in  1  core write (1) / read (0)
c_addr  in  AW  core address
c_wdata  in  DW  core write data
c_be  in  DW/8  core byte enables
c_done  out  1  one-cycle completion pulse to core
c_rdata  out  DW  read data; valid when c_done=1
c_err  out  1  timeout flag; valid when c_done=1
d_req, d_we, d_addr, d_wdata, d_be  in  as port C  loader request fields
d_done, d_rdata, d_err  out  as port C  loader response
m_req  out  1  memory request
m_we  out  1  memory write enable
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_be  out  DW/8  memory byte enables
m_rdata  in  DW  memory read data; sampled when m_ack=1
m_ack  in  1  memory acknowledge, one cycle
busy  out  1  high in BUS and RESP
grant_id  out  1  0=C, 1=D; owner of the current or last transaction

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs are 0, including m_req, *_done, *_rdata, *_err, busy and grant_id. last_grant=D, so C wins the first tie. The timeout counter is 0.
- State IDLE:
  - No request: stay in IDLE.
  - Only one requester asserting req: grant it.
  - Both asserting req: grant the port not equal to last_grant (round-robin).
  - On grant: register we/addr/wdata/be into m_*, set grant_id and last_grant, clear the counter, go to BUS.
- State BUS:
  - m_req=1; m_* fields are held constant.
  - m_ack=1: capture m_rdata into the granted port's rdata register, err=0, go to RESP. The cycle ack arrives is the same cycle m_req can first be seen.
  - m_ack=0 with TIMEOUT!=0: increment the counter. When the counter reaches TIMEOUT-1 and there is no ack, go to RESP with err=1 and rdata=0. m_req is therefore high for exactly TIMEOUT cycles.
- State RESP:
  - m_req=0; the granted port's done=1 for exactly one cycle. rdata and err hold until that port's next done.
  - Next state is always IDLE. Requests are not sampled in RESP.
  - For writes, rdata is 0.
- Latency and throughput:
  - Request seen in IDLE at cycle N: m_req rises at N+1.
  - Ack at cycle M≥N+1: done at M+1; IDLE at M+2.
  - Minimum is 3 cycles per transaction.
- Requester rule: req still high in the IDLE cycle after done is treated as a new request. The requester must drop req or change its fields on the done cycle.
- m_ack outside BUS (a late ack after a timeout, or a spurious ack) is ignored and has no state change.
- A requester changing its fields while waiting is not supported. The latched values are used.
- Reset asserted mid-transaction: m_req and done drop immediately. No done is issued for the aborted access, and the requester re-issues after reset release.
- Simultaneous: both req in IDLE while a done is in flight for the other port is not possible, because done only occurs in RESP and arbitration only in IDLE.

Test Plan:
1. C read, zero wait: c_req=1, c_addr=0x100, c_we=0 at cycle 0 → m_req=1, m_addr=0x100, m_we=0 at cycle 1. m_ack=1, m_rdata=0xCAFEF00D at cycle 1 → c_done=1, c_rdata=0xCAFEF00D, c_err=0 at cycle 2, m_req=0. IDLE at cycle 3.
2. Round-robin: c_req and d_req both held from reset → grants C, D, C, D (grant_id 0,1,0,1), each done pulsing on the correct port only. d_done/c_done are never asserted together.
3. D write with 3 wait states: d_we=1, d_addr=0x40, d_wdata=0x12345678, d_be=4'b0011 → m_req high 4 cycles with fields stable, ack on the 4th cycle → d_done next cycle, d_rdata=0, d_err=0.
4. Timeout, TIMEOUT=8, no ack → m_req high exactly 8 cycles, then c_done=1, c_err=1, c_rdata=0. An m_ack pulse 2 cycles later causes no done and no state change.
5. Reset mid-BUS: rst=0 on the 2nd cycle of m_req → m_req=0 and busy=0 immediately, no c_done. After release, c_req re-asserts → a normal transaction with C granted first.
6. Back-to-back: D keeps d_req high through d_done while c_req is also high → the next grant goes to C. With only d_req high, D is regranted and m_req rises 2 cycles after d_done.
